// File: rtl/vector_mem_pkg.sv
// Shared types and defaults for the vector memory requester.
// Optional overflow checking is selected by VMEM_ADDR_OVF_CHECK_EN.
package vector_mem_pkg;

    localparam int VMEM_ADDR_W = 19;
    localparam int VMEM_LANES  = 4;
    localparam int VMEM_LANE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DRAIN,
        DONE
    } vmem_state_t;

    function automatic logic [VMEM_LANE_W-1:0] lane_byte(
        input logic [31:0] vec,
        input logic [1:0]  k
    );
        return vec[k*VMEM_LANE_W +: VMEM_LANE_W];
    endfunction

endpackage

// File: rtl/vmem_lane_counter.sv
// Two-bit lane index with synchronous clear/enable and a
// terminal-count flag on the last lane.
module vmem_lane_counter #(
    parameter int LAST = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [1:0] cnt_o,
    output logic       tc_o
);

    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == 2'(LAST));

endmodule

// File: rtl/vector_mem_requester.sv
// Serialises a 4-lane byte vector load/store into single-byte accesses.
// Define VMEM_ADDR_OVF_CHECK_EN to suppress overflowing lanes and add ERR.
module vector_mem_requester
    import vector_mem_pkg::*;
#(
    parameter int ADDR_W = VMEM_ADDR_W,
    parameter int LANES  = VMEM_LANES,
    parameter int LANE_W = VMEM_LANE_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [31:0]       BA,
    input  logic [31:0]       VO,
    input  logic [31:0]       WD,
    output logic              STALL,
    output logic              RSP_VALID,
    output logic [31:0]       RD,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [LANE_W-1:0] M_WD,
    output logic              M_WE,
    output logic              M_RE,
    input  logic [LANE_W-1:0] M_RD
`ifdef VMEM_ADDR_OVF_CHECK_EN
    ,
    output logic              ERR
`endif
);

    vmem_state_t state_q, state_d;

    logic              we_q;
    logic [ADDR_W-1:0] ba_q;
    logic [31:0]       vo_q;
    logic [31:0]       wd_q;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       rd_q;
    logic              pend_q;
    logic [1:0]        pend_lane_q;

    logic        cnt_clr;
    logic        cnt_en;
    logic [1:0]  lane;
    logic        last_lane;
    logic        accept;
    logic        in_acc;
    logic        lane_ok;
    logic [ADDR_W:0] sum;

    logic unused_ba;
    assign unused_ba = ^BA[31:ADDR_W];

    vmem_lane_counter #(
        .LAST(LANES - 1)
    ) u_cnt (
        .clk_i(CLK),
        .rst_i(RST),
        .clr_i(cnt_clr),
        .en_i (cnt_en),
        .cnt_o(lane),
        .tc_o (last_lane)
    );

    assign accept = REQ_VALID && (state_q == IDLE || state_q == DONE);
    assign in_acc = (state_q == ACCESS);

    // One extra bit keeps the carry so overflow can be detected.
    assign sum = {1'b0, ba_q}
               + {{(ADDR_W+1-LANE_W){1'b0}}, lane_byte(vo_q, lane)};

`ifdef VMEM_ADDR_OVF_CHECK_EN
    logic ovf_acc_q;
    logic err_q;

    assign lane_ok = !sum[ADDR_W];
    assign ERR     = err_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_acc_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                ovf_acc_q <= 1'b0;
                err_q     <= 1'b0;
            end else if (in_acc && sum[ADDR_W]) begin
                ovf_acc_q <= 1'b1;
            end
            if (state_q == DRAIN) begin
                err_q <= ovf_acc_q;
            end
        end
    end
`else
    logic unused_carry;
    assign unused_carry = sum[ADDR_W];
    assign lane_ok      = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    state_d = ACCESS;
                    cnt_clr = 1'b1;
                end
            end
            ACCESS: begin
                cnt_en = 1'b1;
                if (last_lane) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (REQ_VALID) begin
                    state_d = ACCESS;
                    cnt_clr = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data trails its strobe by one cycle; drop it into its lane slot.
    always_comb begin
        asm_d = asm_q;
        if (accept) begin
            asm_d = '0;
        end else if (pend_q) begin
            asm_d[pend_lane_q*LANE_W +: LANE_W] = M_RD;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            ba_q        <= '0;
            vo_q        <= '0;
            wd_q        <= '0;
            asm_q       <= '0;
            rd_q        <= '0;
            pend_q      <= 1'b0;
            pend_lane_q <= '0;
        end else begin
            state_q     <= state_d;
            asm_q       <= asm_d;
            pend_q      <= M_RE;
            pend_lane_q <= lane;
            if (accept) begin
                we_q <= REQ_WE;
                ba_q <= BA[ADDR_W-1:0];
                vo_q <= VO;
                wd_q <= WD;
            end
            if (state_q == DRAIN && !we_q) begin
                rd_q <= asm_d;
            end
        end
    end

    assign REQ_READY = (state_q == IDLE) || (state_q == DONE);
    assign STALL     = (REQ_VALID && REQ_READY)
                     || (state_q == ACCESS) || (state_q == DRAIN);
    assign RSP_VALID = (state_q == DONE);
    assign RD        = rd_q;
    assign M_ADDR    = in_acc ? sum[ADDR_W-1:0] : '0;
    assign M_WE      = in_acc && we_q && lane_ok;
    assign M_RE      = in_acc && !we_q && lane_ok;
    assign M_WD      = (in_acc && we_q) ? lane_byte(wd_q, lane) : '0;

endmodule

// File: doc/vector_mem_requester.md
Name: vector_mem_requester

Overview:
- Pipeline-side initiator for the byte-wide vector data memory.
- Accepts one 32-bit vector load or store request from the MEM stage, made of a base address and four 8-bit lane offsets.
- Serialises the request into four single-byte memory accesses and reassembles load bytes into a 32-bit result.
- Holds the pipeline stalled until the access completes. Sits between the MEM-stage control and the 8-bit synchronous memory macro.

Parameters:
- ADDR_W, 19, memory byte-address width.
- LANES, 4, lanes per vector (fixed by the ISA; other values unsupported).
- LANE_W, 8, bits per lane and per memory word.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  block can accept a request this cycle.
- REQ_WE  in  1  1 = store, 0 = load.
- BA  in  32  base address; only [ADDR_W-1:0] used.
- VO  in  32  lane offsets; lane k = VO[8k+7:8k], unsigned.
- WD  in  32  store data; lane k = WD[8k+7:8k].
- STALL  out  1  stall request to the pipeline.
- RSP_VALID  out  1  one-cycle completion pulse.
- RD  out  32  assembled load data.
- M_ADDR  out  ADDR_W  memory address.
- M_WD  out  8  memory write data.
- M_WE  out  1  memory write enable.
- M_RE  out  1  memory read enable.
- M_RD  in  8  memory read data, valid one cycle after M_RE.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - RST forces state IDLE and lane counter 0.
  - Outputs go to: RSP_VALID=0, M_WE=0, M_RE=0, M_ADDR=0, M_WD=0, RD=0, REQ_READY=1, STALL=0.
  - Reset mid-operation aborts immediately. No partial RD update, no further memory strobes.
- State machine: IDLE, ACCESS, DRAIN, DONE.
  - IDLE: REQ_READY=1. On REQ_VALID, capture BA, VO, WD, REQ_WE, then go to ACCESS with lane=0.
  - ACCESS: four cycles, lane 0..3.
    - M_ADDR = (BA[ADDR_W-1:0] + zero-extended lane offset) mod 2^ADDR_W. Wrap-around is silent.
    - Store: M_WE=1, M_WD = lane byte of WD.
    - Load: M_RE=1.
    - lane increments each cycle; after lane 3, go to DRAIN.
  - DRAIN: one cycle.
    - M_WE=0, M_RE=0.
    - Load: captures the lane-3 byte. Lane k byte arriving on M_RD in the cycle after its issue goes to assembly bits [8k+7:8k].
    - Store: DRAIN is also taken, so latency is uniform.
  - DONE: one cycle.
    - RSP_VALID=1, STALL=0, REQ_READY=1.
    - Load: RD was updated from the assembly register at the DRAIN→DONE edge.
    - A REQ_VALID seen in DONE is accepted exactly as in IDLE (back-to-back). Otherwise return to IDLE.
- STALL = REQ_VALID in IDLE or DONE, or state ∈ {ACCESS, DRAIN}.
- Latency: request accepted at edge E. Lanes are issued in cycles E+1..E+4, DRAIN is E+5, RSP_VALID is E+6. That is 6 cycles from acceptance to response, identical for loads and stores.
- RD holds its value until the next load completes. Stores never modify RD.
- Inputs BA, VO, WD and REQ_WE are ignored outside an accepting cycle. Changes during ACCESS have no effect.
- M_WE and M_RE are never both high, and never high outside ACCESS.

Optional Feature:
- Macro: VMEM_ADDR_OVF_CHECK_EN.
- Defined:
  - Adds output ERR (1 bit).
  - Any lane whose unwrapped sum BA[ADDR_W-1:0]+offset ≥ 2^ADDR_W is suppressed: no M_WE/M_RE that cycle, and its RD byte is 0.
  - ERR is set with RSP_VALID, held until the next accepted request, and cleared by RST.
- Undefined: no ERR port; addresses wrap modulo 2^ADDR_W.

Decomposition:
- Package vector_mem_pkg holds:
  - LANES, LANE_W, ADDR_W defaults.
  - Enum vmem_state_t {IDLE, ACCESS, DRAIN, DONE}.
  - Function lane_byte(vec, k).
- One natural sub-module: vmem_lane_counter. It is a 2-bit counter with clear/enable and a terminal-count flag marking lane 3.

Test Plan:
- Store, BA=0x00100, VO=0x03020100, WD=0xDDCCBBAA → M_ADDR 0x100..0x103 in consecutive cycles with M_WD AA, BB, CC, DD; M_WE high exactly 4 cycles; RSP_VALID at E+6; RD unchanged.
- Load after that store, same BA/VO → M_RE 4 cycles; RD=0xDDCCBBAA with RSP_VALID at E+6; STALL high E through E+5.
- Load, BA=0x7FFFE, VO=0x00030201 → M_ADDR 0x7FFFF, 0x00000, 0x00001, 0x7FFFE. With VMEM_ADDR_OVF_CHECK_EN: lanes 1 and 2 suppressed, their RD bytes 0, ERR=1.
- Back-to-back: second request asserted in DONE → accepted without an IDLE cycle; second response at 6 cycles after its acceptance.
- RST asserted during ACCESS lane 2 of a load → M_RE low asynchronously; no RSP_VALID; RD keeps its reset value 0; next request behaves normally.
- Input change during ACCESS (WD altered after acceptance) → M_WD follows the captured WD only.
